// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing a single FPU adder among N_REQ requesters.
// Define FPU_ARB_WDOG_EN to bound WAIT with a TIMEOUT response after WDOG_CYCLES.
module fpu_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int STATUS_W    = 4,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                      clock_100Khz,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_op_a,
    input  logic [N_REQ*DATA_W-1:0]   req_op_b,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [STATUS_W-1:0]       rsp_status,
    output logic [DATA_W-1:0]         fpu_op_a,
    output logic [DATA_W-1:0]         fpu_op_b,
    output logic                      fpu_start,
    input  logic                      fpu_done,
    input  logic [DATA_W-1:0]         fpu_data,
    input  logic [STATUS_W-1:0]       fpu_status
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic                start_q, start_d;
    logic                found;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    cand;
`ifdef FPU_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
`endif

    // First requesting index at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_valid_d  = '0;
        start_d      = 1'b0;
        req_ready    = '0;
`ifdef FPU_ARB_WDOG_EN
        wdog_d       = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready = N_REQ'(1) << pick;
                    gnt_d     = pick;
                    op_a_d    = req_op_a[int'(pick)*DATA_W +: DATA_W];
                    op_b_d    = req_op_b[int'(pick)*DATA_W +: DATA_W];
                    start_d   = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef FPU_ARB_WDOG_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                if (fpu_done) begin
                    rsp_data_d   = fpu_data;
                    rsp_status_d = fpu_status;
                    rsp_valid_d  = N_REQ'(1) << gnt_q;
                    state_d      = RESPOND;
                end
`ifdef FPU_ARB_WDOG_EN
                // A real completion on the final cycle still wins over the timeout.
                else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                    rsp_data_d   = '0;
                    rsp_status_d = {STATUS_W{1'b1}};
                    rsp_valid_d  = N_REQ'(1) << gnt_q;
                    state_d      = RESPOND;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            RESPOND: begin
                ptr_d   = (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) req_ready = '0;
    end

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_valid_q  <= '0;
            start_q      <= 1'b0;
`ifdef FPU_ARB_WDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_valid_q  <= rsp_valid_d;
            start_q      <= start_d;
`ifdef FPU_ARB_WDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_status = rsp_status_q;
    assign fpu_op_a   = op_a_q;
    assign fpu_op_b   = op_b_q;
    assign fpu_start  = start_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: directed vectors feed scoreboard queues that an
// independent monitor drains, with a behavioural FPU model on the other side.
module tb_fpu_arbiter;
    localparam int N_REQ       = 4;
    localparam int DATA_W      = 32;
    localparam int STATUS_W    = 4;
    localparam int WDOG_CYCLES = 64;

    typedef struct {
        int                  idx;
        logic [DATA_W-1:0]   data;
        logic [STATUS_W-1:0] status;
    } rsp_t;

    logic                    clock;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_op_a;
    logic [N_REQ*DATA_W-1:0] req_op_b;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [STATUS_W-1:0]     rsp_status;
    logic [DATA_W-1:0]       fpu_op_a;
    logic [DATA_W-1:0]       fpu_op_b;
    logic                    fpu_start;
    logic                    fpu_done;
    logic [DATA_W-1:0]       fpu_data;
    logic [STATUS_W-1:0]     fpu_status;

    // Hand-computed sums in the sign/exp(bias 511)/21-bit mantissa format.
    logic [DATA_W-1:0]   vec_a [7] = '{32'h40000000, 32'h3FE00000, 32'h40000000, 32'h40200000,
                                       32'h40200000, 32'h3FF00000, 32'h3FE00000};
    logic [DATA_W-1:0]   vec_b [7] = '{32'h3FE00000, 32'h3FC00000, 32'h40000000, 32'h40000000,
                                       32'h40200000, 32'h3FC00000, 32'h3C200000};
    logic [DATA_W-1:0]   vec_r [7] = '{32'h40100000, 32'h3FF00000, 32'h40200000, 32'h40300000,
                                       32'h40400000, 32'h40000000, 32'h3FE00000};
    logic [STATUS_W-1:0] vec_s [7] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3};

    int   exp_grant_q[$];
    int   exp_issue_q[$];
    rsp_t exp_rsp_q[$];
    int   acc_cyc_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int grant_cnt = 0;
    int rsp_cnt = 0;
    int start_cnt = 0;
    int last_acc = 0;
    int last_start = 0;
    int last_rsp = 0;
    int rsp_expect = 0;
    int fpu_lat = 1;
    bit model_en = 1'b1;
    int pulse_req = 0;
    int pulse_ack = 0;
    logic [N_REQ-1:0] hold = '0;

    fpu_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .STATUS_W(STATUS_W), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clock_100Khz(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_op_a(req_op_a),
        .req_op_b(req_op_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .fpu_op_a(fpu_op_a),
        .fpu_op_b(fpu_op_b),
        .fpu_start(fpu_start),
        .fpu_done(fpu_done),
        .fpu_data(fpu_data),
        .fpu_status(fpu_status)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: pops the scoreboard whenever the DUT grants or responds.
    initial begin : monitor
        int   g;
        rsp_t e;
        forever begin
            @(negedge clock);
            if (req_ready != '0) begin
                grant_cnt++;
                last_acc = cyc;
                acc_cyc_q.push_back(cyc);
                if (exp_grant_q.size() == 0) checkOutput("unexpected grant", 64'(req_ready), 64'd0);
                else begin
                    g = exp_grant_q.pop_front();
                    checkOutput("req_ready one-hot", 64'(req_ready), 64'(1) << g);
                end
            end
            if (fpu_start) begin
                start_cnt++;
                last_start = cyc;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                last_rsp = cyc;
                if (exp_rsp_q.size() == 0) checkOutput("unexpected response", 64'(rsp_valid), 64'd0);
                else begin
                    e = exp_rsp_q.pop_front();
                    checkOutput("rsp_valid one-hot", 64'(rsp_valid), 64'(1) << e.idx);
                    checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
                    checkOutput("rsp_status", 64'(rsp_status), 64'(e.status));
                end
            end
        end
    end

    // FPU model: answers each start after fpu_lat cycles, or fires spurious dones on request.
    initial begin : fpu_model
        int cur = 0;
        int countdown = 0;
        bit drop_chk = 1'b0;
        fpu_done = 1'b0;
        fpu_data = '0;
        fpu_status = '0;
        forever begin
            @(negedge clock);
            if (reset) drop_chk = 1'b1;
            if (countdown > 0 && !drop_chk) begin
                checkOutput("fpu_op_a stable", 64'(fpu_op_a), 64'(vec_a[cur]));
                checkOutput("fpu_op_b stable", 64'(fpu_op_b), 64'(vec_b[cur]));
            end
            if (fpu_start && model_en) begin
                if (exp_issue_q.size() == 0) checkOutput("unexpected fpu_start", 64'd1, 64'd0);
                else begin
                    cur = exp_issue_q.pop_front();
                    checkOutput("fpu_op_a at start", 64'(fpu_op_a), 64'(vec_a[cur]));
                    checkOutput("fpu_op_b at start", 64'(fpu_op_b), 64'(vec_b[cur]));
                    countdown = fpu_lat;
                    drop_chk = 1'b0;
                end
            end
            @(posedge clock);
            #1;
            fpu_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    fpu_done = 1'b1;
                    fpu_data = vec_r[cur];
                    fpu_status = vec_s[cur];
                end
            end else if (pulse_req != pulse_ack) begin
                pulse_ack = pulse_req;
                fpu_done = 1'b1;
                fpu_data = 32'hBAD0BAD0;
                fpu_status = 4'h1;
            end
        end
    end

    // One clock of requester behaviour: drop req_valid once accepted unless held.
    task automatic stepCycle();
        logic [N_REQ-1:0] r;
        @(negedge clock);
        r = req_ready;
        @(posedge clock);
        #1;
        req_valid = req_valid & ~(r & ~hold);
    endtask

    task automatic applyStimulus(input int idx, input int v);
        req_op_a[idx*DATA_W +: DATA_W] = vec_a[v];
        req_op_b[idx*DATA_W +: DATA_W] = vec_b[v];
        req_valid[idx] = 1'b1;
    endtask

    task automatic expectOp(input int idx, input int v, input bit with_issue, input bit with_rsp);
        rsp_t e;
        exp_grant_q.push_back(idx);
        if (with_issue) exp_issue_q.push_back(v);
        if (with_rsp) begin
            e.idx = idx;
            e.data = vec_r[v];
            e.status = vec_s[v];
            exp_rsp_q.push_back(e);
            rsp_expect++;
        end
    endtask

    task automatic waitAll(input int budget);
        int n = 0;
        while (rsp_cnt < rsp_expect && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("response count", 64'(rsp_cnt), 64'(rsp_expect));
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req_valid = '0;
        hold = '0;
        repeat (2) stepCycle();
        reset = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        $display("[TB] reset state check: %s", tag);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset rsp_status", 64'(rsp_status), 64'd0);
        checkOutput("reset fpu_op_a", 64'(fpu_op_a), 64'd0);
        checkOutput("reset fpu_op_b", 64'(fpu_op_b), 64'd0);
        checkOutput("reset fpu_start", 64'(fpu_start), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin : stimulus
        int base;
        int n;
        int pre_rsp;
        int pre_start;
        reset = 1'b1;
        req_valid = '0;
        req_op_a = '0;
        req_op_b = '0;
        resetDut();
        checkReset("power-up");

        $display("[TB] single request, FPU latency 3");
        fpu_lat = 3;
        expectOp(0, 0, 1'b1, 1'b1);
        applyStimulus(0, 0);
        waitAll(40);
        checkOutput("accept to start", 64'(last_start - last_acc), 64'd1);
        checkOutput("start to response", 64'(last_rsp - last_start), 64'd4);

        $display("[TB] all four requesting, round robin");
        resetDut();
        fpu_lat = 1;
        acc_cyc_q.delete();
        for (int i = 0; i < N_REQ; i++) expectOp(i, i, 1'b1, 1'b1);
        expectOp(0, 0, 1'b1, 1'b1);
        hold = 4'b0001;
        base = grant_cnt;
        for (int i = 0; i < N_REQ; i++) applyStimulus(i, i);
        n = 0;
        while (grant_cnt < base + 4 && n < 100) begin
            stepCycle();
            n++;
        end
        hold = '0;
        waitAll(100);
        checkOutput("accept count", 64'(acc_cyc_q.size()), 64'd5);
        for (int i = 1; i < 5; i++)
            checkOutput("accept spacing", 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd4);
        checkOutput("start to response lat1", 64'(last_rsp - last_start), 64'd2);

        $display("[TB] pointer after req2 favours req3 over req1");
        expectOp(2, 4, 1'b1, 1'b1);
        applyStimulus(2, 4);
        waitAll(40);
        expectOp(3, 6, 1'b1, 1'b1);
        expectOp(1, 5, 1'b1, 1'b1);
        applyStimulus(1, 5);
        applyStimulus(3, 6);
        waitAll(60);

        $display("[TB] spurious fpu_done in IDLE and ISSUE");
        pre_rsp = rsp_cnt;
        pre_start = start_cnt;
        #2;
        pulse_req++;
        repeat (3) stepCycle();
        checkOutput("idle done: no response", 64'(rsp_cnt), 64'(pre_rsp));
        checkOutput("idle done: no start", 64'(start_cnt), 64'(pre_start));
        fpu_lat = 3;
        expectOp(0, 1, 1'b1, 1'b1);
        applyStimulus(0, 1);
        #2;
        pulse_req++;
        waitAll(40);
        checkOutput("issue done ignored", 64'(last_rsp - last_start), 64'd4);

        $display("[TB] reset while waiting on the FPU");
        expectOp(3, 2, 1'b1, 1'b0);
        applyStimulus(3, 2);
        stepCycle();
        stepCycle();
        reset = 1'b1;
        pre_rsp = rsp_cnt;
        stepCycle();
        reset = 1'b0;
        checkReset("reset in WAIT");
        repeat (4) stepCycle();
        checkOutput("no response after reset", 64'(rsp_cnt), 64'(pre_rsp));
        fpu_lat = 1;
        expectOp(0, 3, 1'b1, 1'b1);
        expectOp(2, 4, 1'b1, 1'b1);
        applyStimulus(0, 3);
        applyStimulus(2, 4);
        waitAll(60);

        $display("[TB] FPU never completes");
        model_en = 1'b0;
        exp_grant_q.push_back(1);
        pre_rsp = rsp_cnt;
        pre_start = start_cnt;
`ifdef FPU_ARB_WDOG_EN
        begin
            rsp_t e;
            e.idx = 1;
            e.data = '0;
            e.status = 4'hF;
            exp_rsp_q.push_back(e);
            rsp_expect++;
        end
        applyStimulus(1, 5);
        waitAll(WDOG_CYCLES + 40);
        checkOutput("watchdog timing", 64'(last_rsp - last_start), 64'(WDOG_CYCLES + 1));
`else
        applyStimulus(1, 5);
        repeat (WDOG_CYCLES + 20) stepCycle();
        checkOutput("still waiting: no response", 64'(rsp_cnt), 64'(pre_rsp));
        checkOutput("still waiting: one start", 64'(start_cnt), 64'(pre_start + 1));
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkReset("reset releases WAIT");
`endif
        model_en = 1'b1;
        repeat (2) stepCycle();

        checkOutput("grant queue drained", 64'(exp_grant_q.size()), 64'd0);
        checkOutput("issue queue drained", 64'(exp_issue_q.size()), 64'd0);
        checkOutput("response queue drained", 64'(exp_rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
